// File: rtl/pipe_skid_48bit.sv
// Two-entry skid buffer for the receiving end of a 48-bit datapath stage.
// REGI=0 collapses the block to a combinational wire-through.
module pipe_skid_48bit #(
    parameter int REGI = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic [47:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [47:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [1:0]  level
);

    // Handshake: a word moves on a rising edge where valid && ready; a source
    // holding valid keeps its data stable until that edge. level exposes state.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    generate
        if (REGI != 0) begin : g_reg
            state_t      state_q, state_d;
            logic [47:0] main_q, main_d;
            logic [47:0] skid_q, skid_d;
            logic        in_xfer, out_xfer;

            // in_ready looks only at registered state and reset/flush, never out_ready.
            assign in_ready  = (state_q != FULL) && !reset && !flush;
            assign out_valid = (state_q != EMPTY);
            assign out_data  = main_q;
            assign level     = state_q;
            assign in_xfer   = in_valid && in_ready;
            assign out_xfer  = out_valid && out_ready;

            always_comb begin
                state_d = state_q;
                main_d  = main_q;
                skid_d  = skid_q;
                case (state_q)
                    EMPTY: begin
                        if (in_xfer) begin
                            main_d  = in_data;
                            state_d = ONE;
                        end
                    end
                    ONE: begin
                        if (in_xfer && out_xfer) begin
                            main_d = in_data;
                        end else if (in_xfer) begin
                            skid_d  = in_data;
                            state_d = FULL;
                        end else if (out_xfer) begin
                            state_d = EMPTY;
                        end
                    end
                    FULL: begin
                        if (out_xfer) begin
                            main_d  = skid_q;
                            state_d = ONE;
                        end
                    end
                    default: state_d = EMPTY;
                endcase
            end

            always_ff @(posedge clk) begin
                if (reset || flush) begin
                    state_q <= EMPTY;
                    main_q  <= '0;
                    skid_q  <= '0;
                end else begin
                    state_q <= state_d;
                    main_q  <= main_d;
                    skid_q  <= skid_d;
                end
            end
        end else begin : g_bypass
            logic unused_ctrl;
            assign unused_ctrl = ^{clk, reset, flush};
            assign out_data    = in_data;
            assign out_valid   = in_valid;
            assign in_ready    = out_ready;
            assign level       = 2'd0;
        end
    endgenerate

endmodule

// File: tb/tb_pipe_skid_48bit.sv
// Scoreboard bench for pipe_skid_48bit: registered instance against a queue
// model, plus a bypass instance checked against its inputs.
module tb_pipe_skid_48bit;

    logic        clk = 1'b0;
    logic        reset, flush;
    logic [47:0] in_data;
    logic        in_valid, out_ready;
    logic        in_ready, out_valid;
    logic [47:0] out_data;
    logic [1:0]  level;

    logic [47:0] b_in_data;
    logic        b_in_valid, b_out_ready;
    logic        b_in_ready, b_out_valid;
    logic [47:0] b_out_data;
    logic [1:0]  b_level;

    logic [47:0] exp_q[$];
    logic [47:0] last_out;
    logic        last_acc;
    logic        started = 1'b0;
    int          n_vec = 0;
    int          n_mis = 0;

    // clock/reset
    always #5 clk = ~clk;

    pipe_skid_48bit #(.REGI(1)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .level(level)
    );

    pipe_skid_48bit #(.REGI(0)) dut_byp (
        .clk(clk), .reset(reset), .flush(flush),
        .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .level(b_level)
    );

    task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Reference model: FIFO of accepted words, capacity two, cleared by reset/flush.
    always @(posedge clk) begin
        logic m_rdy, m_out;
        started = 1'b1;
        m_rdy    = (exp_q.size() < 2) && !reset && !flush;
        m_out    = (exp_q.size() != 0) && out_ready;
        last_acc = in_valid && m_rdy;
        if (reset || flush) begin
            exp_q.delete();
            last_out = '0;
        end else begin
            if (m_out) last_out = exp_q.pop_front();
            if (last_acc) exp_q.push_back(in_data);
        end
    end

    // Monitor: compare DUT outputs with the model away from the active edge.
    always @(negedge clk) begin
        if (started) begin
            chk("level", 48'(level), 48'(exp_q.size()));
            chk("out_valid", 48'(out_valid), 48'(exp_q.size() != 0));
            chk("in_ready", 48'(in_ready), 48'((exp_q.size() < 2) && !reset && !flush));
            if (exp_q.size() != 0) chk("out_data", out_data, exp_q[0]);
            else                   chk("out_data_idle", out_data, last_out);
            chk("byp_out_data", b_out_data, b_in_data);
            chk("byp_out_valid", 48'(b_out_valid), 48'(b_in_valid));
            chk("byp_in_ready", 48'(b_in_ready), 48'(b_out_ready));
            chk("byp_level", 48'(b_level), 48'd0);
        end
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #2;
        b_in_valid  = 1'($urandom_range(0, 1));
        b_out_ready = 1'($urandom_range(0, 1));
        b_in_data   = ($urandom_range(0, 3) == 0) ? 48'hFFFF_FFFF_FFFF
                                                  : {16'($urandom), 32'($urandom)};
    endtask

    task automatic send_held(input logic [47:0] d, input logic rdy_after);
        int waited = 0;
        in_valid = 1'b1;
        in_data  = d;
        tick();
        while (!last_acc && waited < 20) begin
            if (waited == 1) out_ready = rdy_after;
            waited++;
            tick();
        end
        if (!last_acc) begin
            n_vec++;
            n_mis++;
            $display("FAIL accept_timeout: word %h not accepted within 20 cycles", d);
        end
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0;
        in_valid = 1'b1; in_data = 48'hAAAA_AAAA_AAAA; out_ready = 1'b0;
        b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b0;
        tick(); tick();
        reset = 1'b0; in_valid = 1'b0;
        tick();

        // streaming
        out_ready = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            in_valid = 1'b1; in_data = 48'(k);
            tick();
        end
        in_valid = 1'b0;
        tick();

        // backpressure: 10 and 20 fill the buffer, 30 waits for space
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 48'h10; tick();
        in_data = 48'h20; tick();
        send_held(48'h30, 1'b1);
        in_valid = 1'b0;
        repeat (3) tick();

        // simultaneous in/out while holding one word
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 48'h5; tick();
        in_data = 48'h6; out_ready = 1'b1; tick();
        in_valid = 1'b0; out_ready = 1'b0; tick();
        out_ready = 1'b1; tick();

        // flush while full with a word offered
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 48'h7; tick();
        in_data = 48'h8; tick();
        in_data = 48'h9; flush = 1'b1; tick();
        flush = 1'b0; in_valid = 1'b0; tick();

        // random traffic; source holds a word until it is accepted
        for (int i = 0; i < 3000; i++) begin
            if (!(in_valid && !last_acc)) begin
                in_valid = 1'($urandom_range(0, 3) != 0);
                in_data  = {16'($urandom), 32'($urandom)};
            end
            out_ready = 1'($urandom_range(0, 2) != 0);
            flush     = 1'($urandom_range(0, 60) == 0);
            reset     = 1'($urandom_range(0, 250) == 0);
            tick();
        end
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (4) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule

// File: doc/pipe_skid_48bit.md
# pipe_skid_48bit

Receiving end of a 48-bit DSP48A1 datapath stage. Accepts 48-bit words from an upstream producer over a valid/ready handshake and presents them to a downstream consumer. Up to two words are buffered, so the upstream side never loses data when the consumer stalls. In registered mode, no combinational path connects `out_ready` to `in_ready`. With `REGI = 0` the block becomes a wire-through, mirroring the bypass option of the datapath's pipeline registers.

## Interface
- `REGI`, default 1: 1 = registered two-entry skid buffer; 0 = combinational pass-through.
- `clk`  input  1  clock; all state updates on the rising edge.
- `reset`  input  1  synchronous, active-high; clock clk.
- `flush`  input  1  synchronous, active-high; discards buffered words. Same effect as reset on the buffer state.
- `in_data`  input  48  upstream word.
- `in_valid`  input  1  `in_data` is valid.
- `in_ready`  output  1  block can accept a word this cycle.
- `out_data`  output  48  word presented downstream.
- `out_valid`  output  1  `out_data` is valid.
- `out_ready`  input  1  downstream accepts `out_data` this cycle.
- `level`  output  2  number of words buffered (0..2).

## Operation
- Input transfer happens at a rising edge where `in_valid && in_ready`.
- Output transfer happens at a rising edge where `out_valid && out_ready`.
- Storage is a main register (drives `out_data`) and a skid register. The state machine is EMPTY / ONE / FULL, encoded by `level` = 0 / 1 / 2.
- `out_valid = (level != 0)`.
- `in_ready = (level != 2) && !reset && !flush`. It depends only on registered state and the reset/flush inputs, never on `out_ready`.
- Transitions out of EMPTY:
  - Input transfer: main ← `in_data`, go to ONE.
  - Otherwise: stay in EMPTY.
- Transitions out of ONE:
  - Input and output transfer together: main ← `in_data`, stay in ONE.
  - Input only: skid ← `in_data`, go to FULL.
  - Output only: go to EMPTY.
  - Neither: hold.
- Transitions out of FULL (no input transfer possible):
  - Output transfer: main ← skid, go to ONE.
  - Otherwise: hold.
- Ordering: words leave in exactly the order they were accepted. No word is duplicated or dropped.
- `out_data` holds its value while `out_valid && !out_ready`. In EMPTY it holds the last value.
- `reset` or `flush` high at an edge: `level` ← 0. Main and skid registers ← 0. This takes priority over any transfer in the same cycle; a word offered in that cycle is not accepted, since `in_ready` is low.
- `REGI = 0`:
  - `out_data = in_data`, `out_valid = in_valid`, `in_ready = out_ready`, `level = 0`.
  - `reset` and `flush` have no effect on the data path.
  - Storage registers may be optimised away.

## Timing
- Reset values (`REGI = 1`): `out_valid` 0, `out_data` 48'h0, `level` 0. `in_ready` is 0 during reset and 1 in the first cycle after reset deasserts.
- Latency in ONE or EMPTY: a word accepted at edge N is on `out_data` with `out_valid` = 1 from edge N onward (one-cycle latency).
- A word accepted into FULL reaches `out_data` at the edge after the first output transfer.
- Throughput: one word per cycle sustained when `out_ready` is held high.
- After the downstream stalls with `level` = 2, `in_ready` returns high one cycle after the first output transfer.
- `REGI = 0`: zero latency, purely combinational.

## Test plan
- Reset: hold `reset` for 2 cycles with `in_valid` = 1 and `in_data` = 48'hAAAA_AAAA_AAAA → `in_ready` = 0 and `out_valid` = 0 throughout. First cycle after release: `in_ready` = 1, `level` = 0, `out_data` = 0.
- Streaming: `out_ready` = 1, feed 48'h1, 48'h2, 48'h3 on consecutive edges → `out_data` shows 1, 2, 3 one cycle after each acceptance. `level` stays 1; `in_ready` stays 1.
- Backpressure: `out_ready` = 0, feed 48'h10, 48'h20, 48'h30 → 10 and 20 accepted, `level` = 2, `in_ready` = 0, and 30 is held by the source. Raise `out_ready` → outputs 10, 20, 30 in order with none lost. `in_ready` rises one cycle after 10 leaves.
- Simultaneous transfers in ONE: `level` = 1 holding 48'h5, then `in_data` = 48'h6 with `out_ready` = 1 → 5 consumed, `out_data` = 6, `level` stays 1.
- Flush mid-operation: with `level` = 2, pulse `flush` while `in_valid` = 1 → next cycle `level` = 0, `out_valid` = 0, and the offered word is not accepted.
- Bypass (`REGI = 0`): toggle `in_valid`, `out_ready`, and `in_data` = 48'hFFFF_FFFF_FFFF → outputs follow inputs in the same cycle, and `level` = 0 always.
